// File: rtl/vector_field_scanner.sv
// Double-buffered per-box flow-vector store: the flow engine fills the hidden bank while
// the video side reads the shown bank per pixel, with a fixed 2-cycle latency.
module vector_field_scanner #(
  parameter int VECTOR_BOX_WIDTH = 32,
  parameter int CORD_WIDTH       = $clog2(VECTOR_BOX_WIDTH),
  parameter int BOXES_X          = 20,
  parameter int BOXES_Y          = 15,
  parameter int ADDR_WIDTH       = $clog2(BOXES_X*BOXES_Y)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sof,
  input  logic [CORD_WIDTH-1:0] wr_vec_x,
  input  logic [CORD_WIDTH-1:0] wr_vec_y,
  output logic                  wr_resync,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  input  logic                  pix_eol,
  output logic                  out_valid,
  output logic                  out_sof,
  output logic [CORD_WIDTH-1:0] out_pixel_col,
  output logic [CORD_WIDTH-1:0] out_pixel_row,
  output logic [CORD_WIDTH-1:0] out_vec_x,
  output logic [CORD_WIDTH-1:0] out_vec_y
);
  localparam int NBOX = BOXES_X*BOXES_Y;
  localparam int BXW  = (BOXES_X > 1) ? $clog2(BOXES_X) : 1;
  localparam int BYW  = (BOXES_Y > 1) ? $clog2(BOXES_Y) : 1;
  localparam logic [CORD_WIDTH-1:0] PX_LAST  = CORD_WIDTH'(VECTOR_BOX_WIDTH-1);
  localparam logic [BXW-1:0]        BX_LAST  = BXW'(BOXES_X-1);
  localparam logic [BYW-1:0]        BY_LAST  = BYW'(BOXES_Y-1);
  localparam logic [ADDR_WIDTH-1:0] A_LAST   = ADDR_WIDTH'(NBOX-1);
  localparam logic [ADDR_WIDTH:0]   BANK_OFS = (ADDR_WIDTH+1)'(NBOX);
  localparam logic FILL = 1'b0;
  localparam logic DONE = 1'b1;

  logic                    state, wb, rb, frame_done, have_frame;
  logic [ADDR_WIDTH-1:0]   wa, waddr;
  logic                    accept, swap, rsel;
  logic [ADDR_WIDTH:0]     wa_full, ra_full;
  logic [2*CORD_WIDTH-1:0] mem [2*NBOX];
  logic [2*CORD_WIDTH-1:0] rdata;

  assign wr_ready = (state == FILL);
  assign accept   = wr_valid & wr_ready;
  assign waddr    = wr_sof ? '0 : wa;
  assign swap     = pix_valid & pix_sof & frame_done;
  // the swapping pixel must already read the freshly completed bank
  assign rsel     = swap ? wb : rb;
  assign wa_full  = wb ? BANK_OFS + {1'b0, waddr} : {1'b0, waddr};

  // swap and accept are exclusive: frame_done implies DONE, which blocks accepts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL; wb <= 1'b0; rb <= 1'b0; wa <= '0;
      frame_done <= 1'b0; have_frame <= 1'b0; wr_resync <= 1'b0;
    end else if (swap) begin
      rb <= wb; wb <= ~wb; wa <= '0;
      frame_done <= 1'b0; have_frame <= 1'b1; state <= FILL;
    end else if (accept) begin
      wa <= waddr + 1'b1;
      if (wr_sof && wa != '0) wr_resync <= 1'b1;
      if (waddr == A_LAST) begin
        frame_done <= 1'b1;
        state      <= DONE;
      end
    end
  end

  // display position of the next pixel; sof overrides it for the current one
  logic [CORD_WIDTH-1:0] col_px, row_px, cur_col, cur_row;
  logic [BXW-1:0]        box_x, cur_bx;
  logic [BYW-1:0]        box_y, cur_by;
  logic [ADDR_WIDTH-1:0] box_addr;

  assign cur_col  = pix_sof ? '0 : col_px;
  assign cur_row  = pix_sof ? '0 : row_px;
  assign cur_bx   = pix_sof ? '0 : box_x;
  assign cur_by   = pix_sof ? '0 : box_y;
  assign box_addr = ADDR_WIDTH'(cur_by) * ADDR_WIDTH'(BOXES_X) + ADDR_WIDTH'(cur_bx);
  assign ra_full  = rsel ? BANK_OFS + {1'b0, box_addr} : {1'b0, box_addr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_px <= '0; row_px <= '0; box_x <= '0; box_y <= '0;
    end else if (pix_valid) begin
      if (pix_eol) begin
        col_px <= '0;
        box_x  <= '0;
        if (cur_row == PX_LAST) begin
          row_px <= '0;
          box_y  <= (cur_by == BY_LAST) ? cur_by : cur_by + 1'b1;
        end else begin
          row_px <= cur_row + 1'b1;
          box_y  <= cur_by;
        end
      end else begin
        row_px <= cur_row;
        box_y  <= cur_by;
        if (cur_col == PX_LAST) begin
          col_px <= '0;
          box_x  <= (cur_bx == BX_LAST) ? cur_bx : cur_bx + 1'b1;
        end else begin
          col_px <= cur_col + 1'b1;
          box_x  <= cur_bx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)    mem[wa_full] <= {wr_vec_x, wr_vec_y};
    if (pix_valid) rdata <= mem[ra_full];
  end

  logic [2:1]            vld_pipe;
  logic                  s1_sof;
  logic [CORD_WIDTH-1:0] s1_col, s1_row;

  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0; s1_sof <= 1'b0; s1_col <= '0; s1_row <= '0;
      out_sof <= 1'b0; out_pixel_col <= '0; out_pixel_row <= '0;
      out_vec_x <= '0; out_vec_y <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], pix_valid};
      if (pix_valid) begin
        s1_sof <= pix_sof;
        s1_col <= cur_col;
        s1_row <= cur_row;
      end
      out_sof <= vld_pipe[1] & s1_sof;
      if (vld_pipe[1]) begin
        out_pixel_col <= s1_col;
        out_pixel_row <= s1_row;
        out_vec_x     <= have_frame ? rdata[2*CORD_WIDTH-1:CORD_WIDTH] : '0;
        out_vec_y     <= have_frame ? rdata[CORD_WIDTH-1:0] : '0;
      end
    end
  end
endmodule

// File: tb/tb_vector_field_scanner.sv
// Scoreboard bench: pixel stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_vector_field_scanner;
  localparam int W = 32, BX = 20, BY = 15, N = BX*BY;

  logic clk = 1'b0, reset_n = 1'b1;
  logic wr_valid = 0, wr_ready, wr_sof = 0, wr_resync;
  logic [4:0] wr_vec_x = '0, wr_vec_y = '0;
  logic pix_valid = 0, pix_sof = 0, pix_eol = 0;
  logic out_valid, out_sof;
  logic [4:0] out_pixel_col, out_pixel_row, out_vec_x, out_vec_y;

  always #5 clk = ~clk;

  vector_field_scanner dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sof(wr_sof),
    .wr_vec_x(wr_vec_x), .wr_vec_y(wr_vec_y), .wr_resync(wr_resync),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .out_valid(out_valid), .out_sof(out_sof),
    .out_pixel_col(out_pixel_col), .out_pixel_row(out_pixel_row),
    .out_vec_x(out_vec_x), .out_vec_y(out_vec_y)
  );

  typedef struct packed {
    logic       sof;
    logic [4:0] col, row, vx, vy;
  } exp_t;

  exp_t       q[$];
  int         n_cmp = 0, n_bad = 0;
  logic [9:0] mbuf [N];
  logic [9:0] disp [N];
  int         mwa = 0;
  bit         mdone = 0, mhave = 0, post_swap = 0;
  logic [1:0] vh;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model of which pixels should come out, two cycles after they go in
  always @(posedge clk or negedge reset_n)
    if (!reset_n) vh <= '0;
    else          vh <= {vh[0], pix_valid};

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      chk("out_valid_lat2", int'(out_valid), int'(vh[1]));
      if (out_valid) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          chk("pix", int'({out_sof, out_pixel_col, out_pixel_row, out_vec_x, out_vec_y}), int'(e));
        end
      end
    end
  end

  task automatic write_beat(input bit sof, input logic [4:0] x, input logic [4:0] y);
    int t = 0;
    int a;
    @(negedge clk);
    wr_valid = 1; wr_sof = sof; wr_vec_x = x; wr_vec_y = y;
    while (!wr_ready) begin
      @(negedge clk);
      t++;
      if (t > 5000) begin
        chk("wr_ready_timeout", 0, 1);
        wr_valid = 0; wr_sof = 0;
        return;
      end
    end
    @(posedge clk);
    a = sof ? 0 : mwa;
    mbuf[a] = {x, y};
    mwa = a + 1;
    if (a == N-1) mdone = 1;
    #1 wr_valid = 0; wr_sof = 0;
  endtask

  task automatic write_frame(input int kind);
    logic [4:0] x, y;
    for (int b = 0; b < N; b++) begin
      if (kind == 0) begin x = 5'(b % 16); y = 5'(-(b % 15)); end
      else           begin x = 5'b10000;   y = 5'd15;         end
      write_beat(b == 0, x, y);
    end
    @(negedge clk);
    chk("wr_ready_after_last", int'(wr_ready), 0);
  endtask

  task automatic display_frame(input int lines, input int len0, input int lenr, input bit bubble);
    int len, bx, by;
    bit sof;
    logic [9:0] v;
    for (int y = 0; y < lines; y++) begin
      len = (y == 0) ? len0 : lenr;
      for (int x = 0; x < len; x++) begin
        @(negedge clk);
        if (post_swap) begin
          chk("wr_ready_post_swap", int'(wr_ready), 1);
          post_swap = 0;
        end
        if (bubble) begin
          pix_valid = 0; pix_sof = 0; pix_eol = 0;
          @(negedge clk);
        end
        sof = (x == 0 && y == 0);
        if (sof) begin
          chk("wr_ready_pre_sof", int'(wr_ready), int'(!mdone));
          if (mdone) begin
            disp = mbuf; mhave = 1; mdone = 0; mwa = 0; post_swap = 1;
          end
        end
        pix_valid = 1; pix_sof = sof; pix_eol = (x == len-1);
        bx = x / W; if (bx > BX-1) bx = BX-1;
        by = y / W; if (by > BY-1) by = BY-1;
        v = mhave ? disp[by*BX + bx] : 10'd0;
        q.push_back({sof, 5'(x % W), 5'(y % W), v[9:5], v[4:0]});
      end
    end
    @(negedge clk);
    pix_valid = 0; pix_sof = 0; pix_eol = 0;
  endtask

  initial begin
    #1 reset_n = 0;
    #1;
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_vec_x", int'(out_vec_x), 0);
    chk("rst_vec_y", int'(out_vec_y), 0);
    chk("rst_resync", int'(wr_resync), 0);
    repeat (3) @(negedge clk);
    reset_n = 1;

    // no frame written yet: vectors read as zero
    display_frame(42, 72, 72, 0);

    // frame A, then swap at the next display sof; box 22 must show (6,-7)
    write_frame(0);
    display_frame(42, 72, 72, 0);

    // frame B written while A is displayed; B appears only after the next sof
    fork
      display_frame(42, 72, 72, 0);
      begin repeat (5) @(negedge clk); write_frame(1); end
    join
    display_frame(42, 72, 72, 0);

    // restart mid-frame at beat 137: resync flag, restart at address 0
    for (int b = 0; b < 137; b++) write_beat(b == 0, 5'(b), 5'(b));
    chk("resync_before", int'(wr_resync), 0);
    write_beat(1, 5'd3, 5'd0);
    chk("resync_set", int'(wr_resync), 1);
    for (int b = 1; b < N-1; b++) write_beat(0, 5'(b+3), 5'(b*7));
    chk("wr_ready_at_298", int'(wr_ready), 1);
    write_beat(0, 5'(N-1+3), 5'((N-1)*7));
    @(negedge clk);
    chk("wr_ready_resync_done", int'(wr_ready), 0);
    chk("resync_sticky", int'(wr_resync), 1);
    display_frame(42, 72, 72, 0);

    // box saturation: one 680-pixel line then 499 two-pixel lines
    display_frame(500, 680, 2, 0);

    // alternating bubbles
    display_frame(42, 72, 72, 1);

    // asynchronous reset mid-write and mid-display
    fork
      display_frame(3, 72, 72, 0);
      begin
        repeat (5) @(negedge clk);
        for (int b = 0; b < 100; b++) write_beat(b == 0, 5'b10000, 5'd15);
      end
    join
    @(negedge clk);
    wr_valid = 1; wr_sof = 0; pix_valid = 1;
    #2 reset_n = 0;
    #1;
    chk("arst_wr_ready", int'(wr_ready), 1);
    chk("arst_resync", int'(wr_resync), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_sof", int'(out_sof), 0);
    chk("arst_col", int'(out_pixel_col), 0);
    chk("arst_row", int'(out_pixel_row), 0);
    chk("arst_vec_x", int'(out_vec_x), 0);
    chk("arst_vec_y", int'(out_vec_y), 0);
    q.delete();
    mwa = 0; mdone = 0; mhave = 0; post_swap = 0;
    @(negedge clk);
    wr_valid = 0; pix_valid = 0;
    reset_n = 1;
    display_frame(3, 72, 72, 0);
    chk("post_rst_resync", int'(wr_resync), 0);

    repeat (5) @(negedge clk);
    chk("sb_leftover", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
